execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute stage directly downstream of the decode→execute pipeline register. Consumes its registered operands and controls.
- Computes the ALU result (valE) and resolves branches/jumps against the fetch-predicted PC.
- Runs RV32M MUL/DIV ops on an iterative multi-cycle unit. While that unit is busy, it requests a pipeline stall from ctrl.

Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iterations per MUL/DIV op; must equal XLEN.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- regE_i_valA / regE_i_valB / regE_i_imm  in  32 each  operands and immediate
- regE_i_alu_valA_sel  in  2  00 valA, 01 pc, 10 zero
- regE_i_alu_valB_sel  in  2  00 valB, 01 imm, 10 const 4
- regE_i_alu_func_sel  in  4  add, sub, and, or, xor, sll, srl, sra, slt, sltu
- regE_i_need_jump  in  1  instruction is a branch/jal/jalr
- regE_i_is_jalr  in  1  jalr target form
- regE_i_instr / regE_i_pc / regE_i_pre_pc  in  32 each  instruction, its pc, predicted next pc
- regE_i_commit  in  1  slot holds a valid instruction
- ctrl_i_kill  in  1  abort in-flight MUL/DIV
- execute_o_valE  out  32  result
- execute_o_stall  out  1  freeze regD/regE, bubble next stage
- execute_o_redirect  out  1  mispredict
- execute_o_redirect_pc  out  32  correct next pc

Behaviour:
- ALU is combinational. Shifts use opB[4:0]. slt is signed, sltu unsigned. Add/sub wrap modulo 2^32.
- Branch compare is selected by instr[14:12]: beq, bne, blt, bge, bltu, bgeu. Compares valA against valB.
- Target: pc+imm, or for jalr (valA+imm)&~1.
- actual_pc = taken ? target : pc+4. jal/jalr are always taken.
- redirect = commit && need_jump && actual_pc!=pre_pc. redirect_pc = actual_pc.
- Non-jump instructions never redirect.
- MD op = commit && opcode 0110011 && funct7 0000001. funct3 selects mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on an MD op, stall=1, latch operands and sign info, cnt=0, go BUSY. Otherwise valE = ALU result.
  - BUSY: stall=1. One shift-add (mul) or restoring shift-subtract (div) step per cycle, cnt++. After cnt==MD_CYCLES-1, go DONE.
  - DONE: stall=0, valE = registered result, go IDLE. The pipeline advances at the end of this cycle.
- MD latency: 34 cycles from the cycle the op enters E (1 IDLE + 32 BUSY + 1 DONE).
- redirect is held 0 while in BUSY or DONE (MD ops never jump).
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend. Detected at latch and finished by the normal count.
- Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- ctrl_i_kill in any state: go IDLE next cycle, stall=0 that cycle, result discarded.
- Reset or kill mid-operation: go to IDLE with no partial result visible.
- Reset values: state IDLE, cnt 0, result register 0, stall 0, redirect 0, valE = ALU of current inputs (0 for bubble inputs).
- A bubble (commit=0) never starts MD and never redirects.

Optional Feature:
- Macro EXECUTE_FAST_MUL_EN.
- Defined: mul/mulh/mulhsu/mulhu use a single-cycle combinational 33x33 signed multiplier. No stall and no FSM entry for them; only div/rem iterate.
- Undefined: all eight MD ops use the iterative 34-cycle path.

Decomposition:
- Shared define package holds:
  - alu_valA_sel/alu_valB_sel/alu_func encodings
  - branch funct3 codes
  - MD funct3 codes
  - opcode/funct7 constants
  - FSM state encoding
- One sub-module, execute_muldiv: FSM, counter, operand/remainder registers, sign fix-up. Interface: start, op, a, b, kill → busy, done, result.
- ALU and branch logic stay inline.

Test Plan:
- add x: valA=5, valB=0xFFFFFFFB, sel valA/valB, func add → valE=0, stall=0, redirect=0.
- beq taken mispredict: pc=0x100, imm=0x20, valA=valB=7, pre_pc=0x104 → redirect=1, redirect_pc=0x120. Same with pre_pc=0x120 → redirect=0.
- jalr: valA=0x2003, imm=0 → redirect_pc=0x2002, valE=pc+4.
- div: 0x80000000 / 0xFFFFFFFF → stall high exactly 33 cycles, DONE cycle valE=0x80000000. divu by 0 → 0xFFFFFFFF. rem by 0 → dividend.
- mulh: 0xFFFFFFFF × 0xFFFFFFFF → 0. mulhu same operands → 0xFFFFFFFE. With EXECUTE_FAST_MUL_EN → stall never asserts.
- kill at BUSY cnt=10, and separately rst at cnt=10 → next cycle IDLE, stall=0. A following add completes normally with the correct result.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU selects, branch/MD funct3,
// opcode constants and the MUL/DIV FSM states.
package execute_stage_pkg;

    localparam logic [1:0] SEL_A_VALA = 2'b00;
    localparam logic [1:0] SEL_A_PC   = 2'b01;
    localparam logic [1:0] SEL_A_ZERO = 2'b10;

    localparam logic [1:0] SEL_B_VALB = 2'b00;
    localparam logic [1:0] SEL_B_IMM  = 2'b01;
    localparam logic [1:0] SEL_B_FOUR = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_func_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [6:0] OP_REG     = 7'b0110011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic md_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV)  || (op == MD_REM);
    endfunction

    function automatic logic md_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/execute_muldiv.sv
// Iterative RV32M unit: shift-add multiply, restoring divide, one bit per
// cycle on operand magnitudes with a sign fix-up on the way out.
module execute_muldiv
    import execute_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(MD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

    md_state_e state_q, state_d;
    logic [CW-1:0] cnt;
    logic [XLEN-1:0] hi, lo, dvs;
    logic [2:0] op_q;
    logic neg_q, neg_r;

    logic accept;
    logic sa, sb;
    logic [XLEN-1:0] ma, mb;
    logic [XLEN:0] mul_sum, div_sh, div_df;
    logic div_ge;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            cnt     <= (state_q == MD_BUSY && state_d == MD_BUSY) ?
                       cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                busy = start && !kill;
                if (start && !kill) state_d = MD_BUSY;
            end
            MD_BUSY: begin
                busy = !kill;
                if (kill)              state_d = MD_IDLE;
                else if (cnt == LAST)  state_d = MD_DONE;
            end
            MD_DONE: begin
                done    = !kill;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign accept = (state_q == MD_IDLE) && start && !kill;
    assign sa = md_signed_a(op) && a[XLEN-1];
    assign sb = md_signed_b(op) && b[XLEN-1];
    assign ma = sa ? -a : a;
    assign mb = sb ? -b : b;

    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    assign div_sh  = {hi, lo[XLEN-1]};
    assign div_ge  = div_sh >= {1'b0, dvs};
    assign div_df  = div_sh - {1'b0, dvs};

    // lo carries the multiplier / dividend and shifts out as hi fills up
    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            dvs   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            hi    <= '0;
            op_q  <= op;
            neg_r <= sa;
            if (op[2]) begin
                lo    <= ma;
                dvs   <= mb;
                neg_q <= (sa ^ sb) && (b != '0);
            end else begin
                lo    <= mb;
                dvs   <= ma;
                neg_q <= sa ^ sb;
            end
        end else if (state_q == MD_BUSY) begin
            if (op_q[2]) begin
                hi <= div_ge ? div_df[XLEN-1:0] : div_sh[XLEN-1:0];
                lo <= {lo[XLEN-2:0], div_ge};
            end else begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
        end
    end

    assign prod     = {hi, lo};
    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        result = '0;
        unique case (op_q)
            MD_MUL:                      result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             result = neg_q ? -lo : lo;
            MD_REM, MD_REMU:             result = neg_r ? -hi : hi;
            default:                     result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch resolution and RV32M dispatch.
// EXECUTE_FAST_MUL_EN: single-cycle multiplier; only div/rem iterate.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] regE_i_valA,
    input  logic [XLEN-1:0] regE_i_valB,
    input  logic [XLEN-1:0] regE_i_imm,
    input  logic [1:0]      regE_i_alu_valA_sel,
    input  logic [1:0]      regE_i_alu_valB_sel,
    input  logic [3:0]      regE_i_alu_func_sel,
    input  logic            regE_i_need_jump,
    input  logic            regE_i_is_jalr,
    input  logic [31:0]     regE_i_instr,
    input  logic [XLEN-1:0] regE_i_pc,
    input  logic [XLEN-1:0] regE_i_pre_pc,
    input  logic            regE_i_commit,
    input  logic            ctrl_i_kill,
    output logic [XLEN-1:0] execute_o_valE,
    output logic            execute_o_stall,
    output logic            execute_o_redirect,
    output logic [XLEN-1:0] execute_o_redirect_pc
);

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [XLEN-1:0] op_a, op_b, alu_res;
    logic [4:0] shamt;
    logic cond, taken;
    logic [XLEN-1:0] jalr_sum, target, actual_pc;
    logic md_op, md_start, md_busy, md_done;
    logic [XLEN-1:0] md_result, base_val;
    logic unused_bits;

    assign opcode = regE_i_instr[6:0];
    assign funct3 = regE_i_instr[14:12];
    assign funct7 = regE_i_instr[31:25];
    assign unused_bits = ^{regE_i_instr[24:15], regE_i_instr[11:7]};

    always_comb begin
        op_a = '0;
        unique case (regE_i_alu_valA_sel)
            SEL_A_VALA: op_a = regE_i_valA;
            SEL_A_PC:   op_a = regE_i_pc;
            default:    op_a = '0;
        endcase
    end

    always_comb begin
        op_b = '0;
        unique case (regE_i_alu_valB_sel)
            SEL_B_VALB: op_b = regE_i_valB;
            SEL_B_IMM:  op_b = regE_i_imm;
            SEL_B_FOUR: op_b = XLEN'(4);
            default:    op_b = '0;
        endcase
    end

    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = '0;
        unique case (regE_i_alu_func_sel)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = XLEN'(op_a < op_b);
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        unique case (funct3)
            F3_BEQ:  cond = regE_i_valA == regE_i_valB;
            F3_BNE:  cond = regE_i_valA != regE_i_valB;
            F3_BLT:  cond = $signed(regE_i_valA) <  $signed(regE_i_valB);
            F3_BGE:  cond = $signed(regE_i_valA) >= $signed(regE_i_valB);
            F3_BLTU: cond = regE_i_valA <  regE_i_valB;
            F3_BGEU: cond = regE_i_valA >= regE_i_valB;
            default: cond = 1'b0;
        endcase
    end

    assign taken     = (opcode == OP_JAL) || regE_i_is_jalr || cond;
    assign jalr_sum  = regE_i_valA + regE_i_imm;
    assign target    = regE_i_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                                      : regE_i_pc + regE_i_imm;
    assign actual_pc = taken ? target : regE_i_pc + XLEN'(4);

    assign md_op = regE_i_commit && (opcode == OP_REG) &&
                   (funct7 == F7_MULDIV);

`ifdef EXECUTE_FAST_MUL_EN
    logic signed [XLEN:0] fa, fb;
    logic signed [2*XLEN+1:0] fp;
    logic unused_fast;

    assign md_start = md_op && funct3[2];
    assign fa = {md_signed_a(funct3) && regE_i_valA[XLEN-1], regE_i_valA};
    assign fb = {md_signed_b(funct3) && regE_i_valB[XLEN-1], regE_i_valB};
    assign fp = fa * fb;
    assign unused_fast = ^fp[2*XLEN+1:2*XLEN];
    assign base_val = (md_op && !funct3[2]) ?
                      ((funct3 == MD_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN]) :
                      alu_res;
`else
    assign md_start = md_op;
    assign base_val = alu_res;
`endif

    execute_muldiv #(
        .XLEN      (XLEN),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (funct3),
        .a      (regE_i_valA),
        .b      (regE_i_valB),
        .kill   (ctrl_i_kill),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign execute_o_valE        = md_done ? md_result : base_val;
    assign execute_o_stall       = md_busy;
    assign execute_o_redirect_pc = actual_pc;
    assign execute_o_redirect    = regE_i_commit && regE_i_need_jump &&
                                   (actual_pc != regE_i_pre_pc) &&
                                   !md_busy && !md_done;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against a plain
// arithmetic reference model.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] valA, valB, imm, instr, pc, pre_pc;
    logic [1:0]  asel, bsel;
    logic [3:0]  func;
    logic        need_jump, is_jalr, commit, kill;
    logic [31:0] valE, redirect_pc;
    logic        stall, redirect;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk                   (clk),
        .rst                   (rst),
        .regE_i_valA           (valA),
        .regE_i_valB           (valB),
        .regE_i_imm            (imm),
        .regE_i_alu_valA_sel   (asel),
        .regE_i_alu_valB_sel   (bsel),
        .regE_i_alu_func_sel   (func),
        .regE_i_need_jump      (need_jump),
        .regE_i_is_jalr        (is_jalr),
        .regE_i_instr          (instr),
        .regE_i_pc             (pc),
        .regE_i_pre_pc         (pre_pc),
        .regE_i_commit         (commit),
        .ctrl_i_kill           (kill),
        .execute_o_valE        (valE),
        .execute_o_stall       (stall),
        .execute_o_redirect    (redirect),
        .execute_o_redirect_pc (redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, b,
                                            input logic [3:0] f);
        int sa = a;
        int sb = b;
        case (f)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return sa >>> b[4:0];
            ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] f,
                                           input logic [31:0] a, b);
        int ia = a;
        int ib = b;
        longint la = ia;
        longint lb = ib;
        longint lua = {32'h0, a};
        longint lub = {32'h0, b};
        longint p;
        longint unsigned pu;
        case (f)
            MD_MUL:    begin p = la * lb;  return p[31:0];  end
            MD_MULH:   begin p = la * lb;  return p[63:32]; end
            MD_MULHSU: begin p = la * lub; return p[63:32]; end
            MD_MULHU:  begin pu = lua * lub; return pu[63:32]; end
            MD_DIV: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return ia / ib;
            end
            MD_REM: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
                return ia % ib;
            end
            MD_DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [6:0] opc,
                                       input logic jr, input logic [2:0] f3,
                                       input logic [31:0] a, b);
        int sa = a;
        int sb = b;
        if (opc == 7'b1101111 || jr) return 1'b1;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic bubble();
        valA = 0; valB = 0; imm = 0; instr = 0; pc = 0; pre_pc = 0;
        asel = 0; bsel = 0; func = 0;
        need_jump = 0; is_jalr = 0; commit = 0; kill = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_md(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, b);
        int n = 0;
        int exp_n = 33;
`ifdef EXECUTE_FAST_MUL_EN
        if (!f3[2]) exp_n = 0;
`endif
        bubble();
        commit = 1;
        valA = a;
        valB = b;
        instr = {7'b0000001, 10'h0, f3, 5'd1, 7'b0110011};
        @(negedge clk);
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_stall"}, n, exp_n);
        check({tag, "_val"}, valE, ref_md(f3, a, b));
        check({tag, "_redir"}, {31'b0, redirect}, 0);
        next_cycle();
        bubble();
    endtask

    task automatic abort_test(input bit use_rst);
        run_md_start();
        repeat (11) @(posedge clk);
        #1;
        if (use_rst) rst = 1;
        else kill = 1;
        @(negedge clk);
        if (!use_rst) check("kill_stall", {31'b0, stall}, 0);
        next_cycle();
        rst = 0;
        bubble();
        @(negedge clk);
        check(use_rst ? "rst_idle_stall" : "kill_idle_stall",
              {31'b0, stall}, 0);
        check(use_rst ? "rst_idle_val" : "kill_idle_val", valE, 0);
        next_cycle();
        commit = 1; valA = 123; valB = 456; func = ALU_ADD;
        @(negedge clk);
        check("post_abort_add", valE, 579);
        check("post_abort_stall", {31'b0, stall}, 0);
        next_cycle();
        bubble();
    endtask

    task automatic run_md_start();
        bubble();
        commit = 1;
        valA = 1000;
        valB = 7;
        instr = {7'b0000001, 10'h0, MD_DIV, 5'd1, 7'b0110011};
        @(negedge clk);
        check("abort_start_stall", {31'b0, stall}, 1);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bubble();
        rst = 1;
        @(negedge clk);
        check("rst_val", valE, 0);
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_redir", {31'b0, redirect}, 0);
        next_cycle();
        rst = 0;

        commit = 1; valA = 5; valB = 32'hFFFFFFFB; func = ALU_ADD;
        @(negedge clk);
        check("addx_val", valE, 0);
        check("addx_stall", {31'b0, stall}, 0);
        check("addx_redir", {31'b0, redirect}, 0);
        next_cycle();

        bubble();
        commit = 1; need_jump = 1; instr = 32'h00000063;
        pc = 32'h100; imm = 32'h20; valA = 7; valB = 7; pre_pc = 32'h104;
        @(negedge clk);
        check("beq_redir", {31'b0, redirect}, 1);
        check("beq_pc", redirect_pc, 32'h120);
        next_cycle();
        pre_pc = 32'h120;
        @(negedge clk);
        check("beq_ok_redir", {31'b0, redirect}, 0);
        next_cycle();

        bubble();
        commit = 1; need_jump = 1; is_jalr = 1; instr = 32'h00000067;
        valA = 32'h2003; imm = 0; pc = 32'h400; pre_pc = 32'h404;
        asel = SEL_A_PC; bsel = SEL_B_FOUR; func = ALU_ADD;
        @(negedge clk);
        check("jalr_pc", redirect_pc, 32'h2002);
        check("jalr_redir", {31'b0, redirect}, 1);
        check("jalr_val", valE, 32'h404);
        next_cycle();

        run_md("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_md("divu_z", MD_DIVU, 32'h12345678, 0);
        run_md("rem_z", MD_REM, 32'hDEADBEEF, 0);
        run_md("div_z", MD_DIV, 32'h80000005, 0);
        run_md("mulh", MD_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_md("mulhu", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);

        abort_test(1'b0);
        abort_test(1'b1);

        for (int i = 0; i < 300; i++) begin
            logic [2:0] f3;
            logic [6:0] opc;
            logic [31:0] tgt, act;
            logic tk, exp_r;
            int kind;
            bubble();
            kind = $urandom_range(0, 3);
            commit = ($urandom_range(0, 9) != 0);
            valA = pick_op();
            valB = ($urandom_range(0, 3) == 0) ? valA : pick_op();
            imm = $urandom_range(0, 4095) << 1;
            pc = $urandom & 32'hFFFFFFFC;
            asel = $urandom_range(0, 2);
            bsel = $urandom_range(0, 2);
            func = $urandom_range(0, 9);
            f3 = $urandom_range(0, 7);
            case (kind)
                0: begin
                    opc = ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011;
                    instr = {7'b0, 10'($urandom), f3, 5'd3, opc};
                end
                1: begin
                    opc = 7'b1100011;
                    if (f3 == 3'b010 || f3 == 3'b011) f3 = 3'b000;
                    instr = {7'b0, 10'($urandom), f3, 5'd0, opc};
                    need_jump = 1;
                end
                2: begin
                    opc = 7'b1101111;
                    instr = {25'($urandom), opc};
                    need_jump = 1;
                end
                default: begin
                    opc = 7'b1100111;
                    instr = {17'($urandom), 3'b000, 5'd1, opc};
                    need_jump = 1;
                    is_jalr = 1;
                end
            endcase
            tk = ref_taken(opc, is_jalr, f3, valA, valB);
            tgt = is_jalr ? ((valA + imm) & ~32'd1) : pc + imm;
            act = tk ? tgt : pc + 4;
            case ($urandom_range(0, 2))
                0:       pre_pc = act;
                1:       pre_pc = pc + 4;
                default: pre_pc = $urandom;
            endcase
            exp_r = commit && need_jump && (act != pre_pc);
            @(negedge clk);
            check("rnd_val", valE,
                  ref_alu(asel == 0 ? valA : asel == 1 ? pc : 32'd0,
                          bsel == 0 ? valB : bsel == 1 ? imm : 32'd4,
                          func));
            check("rnd_stall", {31'b0, stall}, 0);
            check("rnd_redir", {31'b0, redirect}, {31'b0, exp_r});
            if (need_jump) check("rnd_rpc", redirect_pc, act);
            next_cycle();
        end

        for (int i = 0; i < 24; i++) begin
            logic [2:0] f3;
            f3 = $urandom_range(0, 7);
            run_md("rnd_md", f3, pick_op(), pick_op());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
